qdriip_axi_traffic_gen: RTL and testbench
=========================================

QDRIIP_AXI_TRAFFIC_GEN -- requirements
Module: qdriip_axi_traffic_gen

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 64: AXI data width, a multiple of 32.
REQ-003 SHALL have parameter NUM_WRITES, default 16: beats per pass, a multiple of BURST_LEN.
REQ-004 SHALL have parameter BURST_LEN, default 4: beats per burst, 1..256.
REQ-005 SHALL have parameter BASE_ADDR, default 0: first beat address.
REQ-006 SHALL have parameter ERR_CNT_WIDTH, default 16: width of the error and pass counters.
REQ-007 SHALL have ports clk in 1 (sole clock) and rst_n in 1 (asynchronous, active-low reset).
REQ-008 SHALL have control ports start in 1, pattern_mode in 1 (0=incrementing, 1=LFSR) and loop_en in 1.
REQ-009 SHALL have status ports busy out 1, done out 1, error_counter out ERR_CNT_WIDTH, pass_count out ERR_CNT_WIDTH and first_err_addr out AXI_ADDR_WIDTH.
REQ-010 SHALL have AXI master write-address ports m_axi_awaddr, m_axi_awlen[7:0], m_axi_awvalid and m_axi_awready.
REQ-011 SHALL have AXI master write-data ports m_axi_wdata, m_axi_wstrb[AXI_DATA_WIDTH/8-1:0], m_axi_wlast, m_axi_wvalid and m_axi_wready.
REQ-012 SHALL have AXI master write-response ports m_axi_bresp[1:0], m_axi_bvalid and m_axi_bready.
REQ-013 SHALL have AXI master read ports m_axi_araddr, m_axi_arlen, m_axi_arvalid, m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid, m_axi_rlast and m_axi_rready.

Function
REQ-014 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA and DONE.
REQ-015 SHALL, in IDLE with start=1, clear error_counter and pass_count, latch pattern_mode, and go to WR_ADDR.
REQ-016 SHALL drive awaddr/araddr for burst b as BASE_ADDR + b*BURST_LEN*(AXI_DATA_WIDTH/8), with awlen = arlen = BURST_LEN-1.
REQ-017 SHALL hold each valid signal and its payload stable until the handshake completes; no valid signal depends on its ready.
REQ-018 SHALL assert wvalid only after the AW handshake, with wstrb all ones and wlast on beat BURST_LEN-1 of the burst.
REQ-019 SHALL assert bready in WR_RESP, then return to WR_ADDR for the next burst, or go to RD_ADDR after the last burst.
REQ-020 SHALL generate beat-i data (i = 0..NUM_WRITES-1) as follows: incrementing mode uses i zero-extended; LFSR mode uses a 32-bit Galois LFSR (poly 0x80200003, seed 0xACE10001) stepped once per beat and replicated to AXI_DATA_WIDTH.
REQ-021 SHALL re-seed the read-side generator identically at RD_ADDR entry of each pass.
REQ-022 SHALL hold rready=1 throughout RD_DATA.
REQ-023 SHALL count one error per accepted R beat with rdata mismatch or rresp!=0.
REQ-024 SHALL count one error per B with bresp!=0.
REQ-025 SHALL count one error per rlast absent on the final burst beat or present on any other beat.
REQ-026 SHALL make error_counter saturating; multiple error causes on the same beat count once.
REQ-027 SHALL, after the last read burst, go to DONE and increment pass_count (wrapping).
REQ-028 SHALL, in DONE with loop_en=1, return to WR_ADDR next cycle without clearing error_counter; with loop_en=0, stay in DONE until start=0, then go to IDLE.
REQ-029 SHALL make busy=1 in every state except IDLE and DONE, and done=1 only in DONE.
REQ-030 SHALL make start and loop_en changes during a pass take effect only at IDLE/DONE.

Reset
REQ-031 SHALL, on rst_n low at any time including mid-burst, immediately force IDLE with all valid signals, bready, rready, busy, done and counters at 0, and the LFSRs at seed.
REQ-032 SHALL not complete an outstanding AXI transaction after reset; the slave is reset by the same rst_n.

Configuration
REQ-033 SHALL, with QDRIIP_TG_FIRST_ERR_EN defined, capture the address of the first erroring R beat since start into first_err_addr, held until the next start from IDLE.
REQ-034 SHALL, without QDRIIP_TG_FIRST_ERR_EN, drive first_err_addr constant 0 and instantiate no capture register.

Verification
REQ-035 SHALL cover: default parameters with an ideal slave and start=1 -> 4 AW, 16 W, 4 B, 4 AR, 16 R beats; done=1, error_counter=0, pass_count=1.
REQ-036 SHALL cover: slave corrupting rdata of beat 5 in incrementing mode -> error_counter=1, first_err_addr=BASE_ADDR+0x28 (macro defined).
REQ-037 SHALL cover: bresp=2'b10 on the second burst and rresp=2'b10 on one beat -> error_counter=2.
REQ-038 SHALL cover: loop_en=1 for 3 passes in LFSR mode with random ready stalls -> pass_count=3, error_counter=0, and valid/payload stable under stall.
REQ-039 SHALL cover: rst_n pulsed low during WR_DATA beat 2 -> awvalid=wvalid=0 and busy=0 in the same cycle; a restart completes cleanly.
REQ-040 SHALL cover: slave asserting rlast on beat 2 of a 4-beat burst -> error_counter=2 (early rlast and missing rlast).

Source files
------------

// File: rtl/qdriip_axi_traffic_gen.sv
// AXI4 write-then-read-back traffic generator for QDRII+ memory bring-up.
// Define QDRIIP_TG_FIRST_ERR_EN to capture the address of the first erroring read beat.
module qdriip_axi_traffic_gen #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 64,
  parameter int                        NUM_WRITES     = 16,
  parameter int                        BURST_LEN      = 4,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = '0,
  parameter int                        ERR_CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        pattern_mode,
  input  logic                        loop_en,
  output logic                        busy,
  output logic                        done,
  output logic [ERR_CNT_WIDTH-1:0]    error_counter,
  output logic [ERR_CNT_WIDTH-1:0]    pass_count,
  output logic [AXI_ADDR_WIDTH-1:0]   first_err_addr,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]                  m_axi_awlen,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wlast,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]                  m_axi_arlen,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  input  logic                        m_axi_rlast,
  output logic                        m_axi_rready
);

  localparam int BYTES      = AXI_DATA_WIDTH / 8;
  localparam int NUM_BURSTS = NUM_WRITES / BURST_LEN;
  localparam int BEAT_W     = $clog2(BURST_LEN + 1);
  localparam int BURST_W    = $clog2(NUM_BURSTS + 1);
  localparam int IDX_W      = $clog2(NUM_WRITES + 1);
  localparam logic [31:0]              LFSR_POLY  = 32'h8020_0003;
  localparam logic [31:0]              LFSR_SEED  = 32'hACE1_0001;
  localparam logic [BEAT_W-1:0]        LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [BURST_W-1:0]       LAST_BURST = BURST_W'(NUM_BURSTS - 1);
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX    = '1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    WR_RESP = 3'd3,
    RD_ADDR = 3'd4,
    RD_DATA = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t                    state_r, state_nxt;
  logic [BURST_W-1:0]        burst_r;
  logic [BEAT_W-1:0]         beat_r;
  logic [31:0]               gen_lfsr_r;
  logic [IDX_W-1:0]          gen_idx_r;
  logic                      mode_r;
  logic                      start_pass_s, loop_pass_s, rd_phase_s, pass_end_s;
  logic                      aw_hs_s, w_hs_s, b_hs_s, ar_hs_s, r_hs_s;
  logic                      last_beat_s, last_burst_s, r_err_s, b_err_s;
  logic [AXI_DATA_WIDTH-1:0] exp_data_s;
  logic [AXI_ADDR_WIDTH-1:0] burst_addr_s;

  // Left-shifting Galois LFSR; feedback from bit 31 into the polynomial taps.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    lfsr_next = {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  assign last_beat_s  = (beat_r == LAST_BEAT);
  assign last_burst_s = (burst_r == LAST_BURST);
  assign aw_hs_s      = m_axi_awvalid && m_axi_awready;
  assign w_hs_s       = m_axi_wvalid && m_axi_wready;
  assign b_hs_s       = m_axi_bvalid && m_axi_bready;
  assign ar_hs_s      = m_axi_arvalid && m_axi_arready;
  assign r_hs_s       = m_axi_rvalid && m_axi_rready;
  assign exp_data_s   = mode_r ? {(AXI_DATA_WIDTH/32){gen_lfsr_r}} : AXI_DATA_WIDTH'(gen_idx_r);
  assign burst_addr_s = BASE_ADDR + AXI_ADDR_WIDTH'(burst_r) * AXI_ADDR_WIDTH'(BURST_LEN * BYTES);

  assign m_axi_awaddr = burst_addr_s;
  assign m_axi_araddr = burst_addr_s;
  assign m_axi_awlen  = 8'(BURST_LEN - 1);
  assign m_axi_arlen  = 8'(BURST_LEN - 1);
  assign m_axi_wdata  = exp_data_s;
  assign m_axi_wstrb  = '1;
  assign m_axi_wlast  = last_beat_s;

  // An erroring beat counts once, whatever mix of data, response and rlast faults it carries.
  assign r_err_s = r_hs_s && ((m_axi_rdata != exp_data_s) || (m_axi_rresp != 2'b00) ||
                              (m_axi_rlast != last_beat_s));
  assign b_err_s = b_hs_s && (m_axi_bresp != 2'b00);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Next-state logic and Moore-decoded handshake/status outputs.
  always_comb begin
    state_nxt     = state_r;
    start_pass_s  = 1'b0;
    loop_pass_s   = 1'b0;
    rd_phase_s    = 1'b0;
    pass_end_s    = 1'b0;
    busy          = 1'b1;
    done          = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    case (state_r)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_pass_s = 1'b1;
          state_nxt    = WR_ADDR;
        end else begin
          state_nxt = IDLE;
        end
      end
      WR_ADDR: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_nxt = WR_DATA;
        else               state_nxt = WR_ADDR;
      end
      WR_DATA: begin
        m_axi_wvalid = 1'b1;
        if (m_axi_wready && last_beat_s) state_nxt = WR_RESP;
        else                             state_nxt = WR_DATA;
      end
      WR_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid && last_burst_s) begin
          rd_phase_s = 1'b1;
          state_nxt  = RD_ADDR;
        end else if (m_axi_bvalid) begin
          state_nxt = WR_ADDR;
        end else begin
          state_nxt = WR_RESP;
        end
      end
      RD_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_nxt = RD_DATA;
        else               state_nxt = RD_ADDR;
      end
      RD_DATA: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && last_beat_s && last_burst_s) begin
          pass_end_s = 1'b1;
          state_nxt  = DONE;
        end else if (m_axi_rvalid && last_beat_s) begin
          state_nxt = RD_ADDR;
        end else begin
          state_nxt = RD_DATA;
        end
      end
      DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (loop_en) begin
          loop_pass_s = 1'b1;
          state_nxt   = WR_ADDR;
        end else if (!start) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Burst/beat position and the pattern generator shared by the write and read phases.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_r    <= '0;
      beat_r     <= '0;
      gen_lfsr_r <= LFSR_SEED;
      gen_idx_r  <= '0;
      mode_r     <= 1'b0;
    end else begin
      if (start_pass_s) mode_r <= pattern_mode;
      if (start_pass_s || loop_pass_s || rd_phase_s) begin
        gen_lfsr_r <= LFSR_SEED;
        gen_idx_r  <= '0;
        burst_r    <= '0;
      end else begin
        if (w_hs_s || r_hs_s) begin
          gen_lfsr_r <= lfsr_next(gen_lfsr_r);
          gen_idx_r  <= gen_idx_r + IDX_W'(1);
        end
        if ((b_hs_s || (r_hs_s && last_beat_s)) && !last_burst_s) burst_r <= burst_r + BURST_W'(1);
      end
      if (aw_hs_s || ar_hs_s)     beat_r <= '0;
      else if (w_hs_s || r_hs_s)  beat_r <= beat_r + BEAT_W'(1);
    end
  end

  // Saturating error counter and wrapping pass counter, both cleared by a fresh start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_counter <= '0;
      pass_count    <= '0;
    end else begin
      if (start_pass_s) begin
        error_counter <= '0;
        pass_count    <= '0;
      end else begin
        if ((r_err_s || b_err_s) && (error_counter != ERR_MAX))
          error_counter <= error_counter + ERR_CNT_WIDTH'(1);
        if (pass_end_s) pass_count <= pass_count + ERR_CNT_WIDTH'(1);
      end
    end
  end

`ifdef QDRIIP_TG_FIRST_ERR_EN
  logic [AXI_ADDR_WIDTH-1:0] first_err_addr_r;
  logic                      first_err_seen_r;
  logic [AXI_ADDR_WIDTH-1:0] beat_addr_s;

  assign beat_addr_s    = BASE_ADDR + AXI_ADDR_WIDTH'(gen_idx_r) * AXI_ADDR_WIDTH'(BYTES);
  assign first_err_addr = first_err_addr_r;

  // Holds the first erroring read-beat address across looped passes until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_err_addr_r <= '0;
      first_err_seen_r <= 1'b0;
    end else if (start_pass_s) begin
      first_err_addr_r <= '0;
      first_err_seen_r <= 1'b0;
    end else if (r_err_s && !first_err_seen_r) begin
      first_err_addr_r <= beat_addr_s;
      first_err_seen_r <= 1'b1;
    end
  end
`else
  assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_qdriip_axi_traffic_gen.sv
// Directed self-checking bench for qdriip_axi_traffic_gen with a fault-injecting AXI slave model.
module tb_qdriip_axi_traffic_gen;

  logic        clk, rst_n, start, pattern_mode, loop_en;
  logic        busy, done;
  logic [15:0] error_counter, pass_count;
  logic [31:0] first_err_addr;
  logic [31:0] awaddr, araddr;
  logic [7:0]  awlen, arlen, wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic [63:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  qdriip_axi_traffic_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern_mode(pattern_mode), .loop_en(loop_en),
    .busy(busy), .done(done), .error_counter(error_counter), .pass_count(pass_count),
    .first_err_addr(first_err_addr),
    .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
    .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rlast(rlast),
    .m_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave model: memory of 64-bit words, random ready stalls, fault-injection knobs.
  logic [63:0] mem [0:31];
  logic        stall_en = 1'b0;
  int          bad_r_data_idx = 999, bad_rresp_idx = 999, bad_b_idx = 999, bad_rlast_burst = 999;
  int          aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt, w_ptr, r_ptr, r_beat;
  logic        r_active;
  logic [7:0]  awlen_seen, wstrb_and;

  assign rvalid = r_active;
  assign rdata  = mem[r_ptr] ^ ((r_cnt == bad_r_data_idx) ? 64'h1 : 64'h0);
  assign rresp  = (r_cnt == bad_rresp_idx) ? 2'b10 : 2'b00;
  assign rlast  = ((ar_cnt - 1) == bad_rlast_burst) ? (r_beat == 2) : (r_beat == 3);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      awready <= 1'b0; wready <= 1'b0; arready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
      r_active <= 1'b0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      w_ptr <= 0; r_ptr <= 0; r_beat <= 0; awlen_seen <= 8'h00; wstrb_and <= 8'hFF;
    end else begin
      awready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      arready <= stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      if (awvalid && awready) begin
        w_ptr <= int'(awaddr >> 3); aw_cnt <= aw_cnt + 1; awlen_seen <= awlen;
      end
      if (wvalid && wready) begin
        mem[w_ptr] <= wdata; w_ptr <= w_ptr + 1; w_cnt <= w_cnt + 1; wstrb_and <= wstrb_and & wstrb;
        if (wlast) begin
          bvalid <= 1'b1;
          bresp  <= (b_cnt == bad_b_idx) ? 2'b10 : 2'b00;
        end
      end
      if (bvalid && bready) begin
        bvalid <= 1'b0; b_cnt <= b_cnt + 1;
      end
      if (arvalid && arready) begin
        r_active <= 1'b1; r_ptr <= int'(araddr >> 3); r_beat <= 0; ar_cnt <= ar_cnt + 1;
      end
      if (rvalid && rready) begin
        r_ptr <= r_ptr + 1; r_beat <= r_beat + 1; r_cnt <= r_cnt + 1;
        if (r_beat == 3) r_active <= 1'b0;
      end
    end
  end

  // Valid/payload stability monitor while a stalled handshake is pending.
  logic        mon_en = 1'b0;
  logic        p_aw = 1'b0, p_w = 1'b0, p_ar = 1'b0;
  logic [39:0] p_aw_pl;
  logic [64:0] p_w_pl;
  logic [31:0] p_ar_pl;

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (p_aw) check_val("aw_stable", {awvalid, awlen, awaddr}, {1'b1, p_aw_pl});
      if (p_w)  check_val("w_stable", {wvalid, wlast, wdata}, {1'b1, p_w_pl});
      if (p_ar) check_val("ar_stable", {arvalid, araddr}, {1'b1, p_ar_pl});
      p_aw = awvalid && !awready; p_aw_pl = {awlen, awaddr};
      p_w  = wvalid && !wready;   p_w_pl  = {wlast, wdata};
      p_ar = arvalid && !arready; p_ar_pl = araddr;
    end else begin
      p_aw = 1'b0; p_w = 1'b0; p_ar = 1'b0;
    end
  end

  task automatic do_reset();
    start = 1'b0; pattern_mode = 1'b0; loop_en = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check_val(tag, done, 1'b1);
  endtask

  task automatic run_pass(input string tag, input logic mode);
    @(negedge clk);
    start = 1'b1; pattern_mode = mode;
    wait_done(tag, 1000);
  endtask

  task automatic end_pass();
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int j;
    logic [31:0] exp_fe;
    do_reset();
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_err", error_counter, 16'd0);
    check_val("rst_pass", pass_count, 16'd0);
    check_val("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b00000);
    check_val("rst_fea", first_err_addr, 32'd0);

    // Ideal slave, incrementing pattern.
    @(negedge clk);
    start = 1'b1; pattern_mode = 1'b0;
    @(negedge clk);
    check_val("busy_running", {busy, done}, 2'b10);
    wait_done("t1_done", 1000);
    check_val("t1_counts", {aw_cnt[7:0], w_cnt[7:0], b_cnt[7:0], ar_cnt[7:0], r_cnt[7:0]},
              {8'd4, 8'd16, 8'd4, 8'd4, 8'd16});
    check_val("t1_err", error_counter, 16'd0);
    check_val("t1_pass", pass_count, 16'd1);
    check_val("t1_busy", busy, 1'b0);
    check_val("t1_awlen_wstrb", {awlen_seen, wstrb_and}, {8'd3, 8'hFF});
    check_val("t1_mem0", mem[0], 64'd0);
    check_val("t1_mem5", mem[5], 64'd5);
    check_val("t1_mem15", mem[15], 64'd15);
    repeat (2) @(negedge clk);
    check_val("t1_hold_done", done, 1'b1);
    end_pass();
    check_val("t1_idle", {busy, done}, 2'b00);

    // Corrupted read beat 5; then a clean restart clears the counters.
    do_reset();
    bad_r_data_idx = 5;
    run_pass("t2_done", 1'b0);
    check_val("t2_err", error_counter, 16'd1);
`ifdef QDRIIP_TG_FIRST_ERR_EN
    exp_fe = 32'h0000_0028;
`else
    exp_fe = 32'h0000_0000;
`endif
    check_val("t2_fea", first_err_addr, exp_fe);
    end_pass();
    bad_r_data_idx = 999;
    run_pass("t2b_done", 1'b0);
    check_val("t2b_err_cleared", error_counter, 16'd0);
    check_val("t2b_pass", pass_count, 16'd1);
    check_val("t2b_fea", first_err_addr, 32'd0);
    end_pass();

    // Error bresp on the second burst and error rresp on one read beat.
    do_reset();
    bad_b_idx = 1; bad_rresp_idx = 9;
    run_pass("t3_done", 1'b0);
    check_val("t3_err", error_counter, 16'd2);
    end_pass();
    bad_b_idx = 999; bad_rresp_idx = 999;

    // Early rlast on beat 2 of burst 1 gives early plus missing rlast errors.
    do_reset();
    bad_rlast_burst = 1;
    run_pass("t4_done", 1'b0);
    check_val("t4_err", error_counter, 16'd2);
    end_pass();
    bad_rlast_burst = 999;

    // Three looped LFSR passes with random ready stalls.
    do_reset();
    stall_en = 1'b1; mon_en = 1'b1;
    @(negedge clk);
    start = 1'b1; pattern_mode = 1'b1; loop_en = 1'b1;
    for (j = 0; j < 3000 && !(pass_count == 16'd2 && busy); j++) @(negedge clk);
    check_val("t5_third_pass", {pass_count, busy}, {16'd2, 1'b1});
    loop_en = 1'b0;
    wait_done("t5_done", 2000);
    check_val("t5_pass", pass_count, 16'd3);
    check_val("t5_err", error_counter, 16'd0);
    check_val("t5_mem0", mem[0], 64'hACE1_0001_ACE1_0001);
    check_val("t5_mem1", mem[1], 64'hD9E2_0001_D9E2_0001);
    check_val("t5_mem2", mem[2], 64'h33E4_0001_33E4_0001);
    end_pass();
    stall_en = 1'b0; mon_en = 1'b0;

    // Reset asserted during write beat 2, then a clean restart.
    do_reset();
    @(negedge clk);
    start = 1'b1; pattern_mode = 1'b0;
    for (j = 0; j < 200 && !(w_cnt == 2 && wvalid); j++) @(negedge clk);
    check_val("t6_at_beat2", {w_cnt == 2, wvalid}, 2'b11);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t6_rst_valid", {awvalid, wvalid, busy}, 3'b000);
    check_val("t6_rst_cnt", {error_counter, pass_count}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass("t6_done", 1'b0);
    check_val("t6_err", error_counter, 16'd0);
    check_val("t6_pass", pass_count, 16'd1);
    check_val("t6_wcnt", w_cnt, 16);
    end_pass();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
